// File: rtl/rst_ctrl.sv
// Chip-level reset controller: async-assert / sync-deassert pad reset conditioning,
// minimum-width reset stretching, software/watchdog re-entry and reset-cause capture.
module rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    output logic       sys_rstn,
    output logic [1:0] rst_cause,
    output logic       rst_done
);

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_PAD = 2'b00;
    localparam logic [1:0] CAUSE_SW  = 2'b01;
    localparam logic [1:0] CAUSE_WDT = 2'b10;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_ok;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    // A low pulse on resetn empties the chain, so a glitch restarts the count from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync[SYNC_STAGES-1];

    // sys_rstn and rst_done are updated alongside the state so they stay glitch-free flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ASSERT;
            cnt       <= '0;
            sys_rstn  <= 1'b0;
            rst_cause <= CAUSE_PAD;
            rst_done  <= 1'b0;
        end else begin
            case (state)
                ASSERT: begin
                    sys_rstn <= 1'b0;
                    rst_done <= 1'b0;
                    if (sync_ok) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state    <= RUN;
                        sys_rstn <= 1'b1;
                        rst_done <= 1'b1;
                    end else begin
                        cnt      <= cnt + CNT_W'(1);
                        sys_rstn <= 1'b0;
                        rst_done <= 1'b0;
                    end
                end
                RUN: begin
                    rst_done <= 1'b0;
                    if (wdt_rst_req) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        sys_rstn  <= 1'b0;
                        rst_cause <= CAUSE_WDT;
                    end else if (sw_rst_req) begin
                        state     <= HOLD;
                        cnt       <= '0;
                        sys_rstn  <= 1'b0;
                        rst_cause <= CAUSE_SW;
                    end
                end
                default: begin
                    state    <= ASSERT;
                    sys_rstn <= 1'b0;
                    rst_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_ctrl.sv
// Bench for rst_ctrl: timeline reference model compared every cycle, a request table,
// directed corner sequences, and a second instance at minimum parameters.
module tb_rst_ctrl;

    localparam int S = 2;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       wdt_rst_req = 1'b0;
    logic       sys_rstn;
    logic [1:0] rst_cause;
    logic       rst_done;

    logic       resetn_m = 1'b1;
    logic       sw_m = 1'b0;
    logic       wdt_m = 1'b0;
    logic       sys_rstn_m;
    logic [1:0] rst_cause_m;
    logic       rst_done_m;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit mon_en = 1'b0;

    rst_ctrl #(.SYNC_STAGES(S), .HOLD_CYCLES(H), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .sw_rst_req(sw_rst_req), .wdt_rst_req(wdt_rst_req),
        .sys_rstn(sys_rstn), .rst_cause(rst_cause), .rst_done(rst_done)
    );

    rst_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .CNT_W(1)) dut_min (
        .clk(clk), .resetn(resetn_m), .sw_rst_req(sw_m), .wdt_rst_req(wdt_m),
        .sys_rstn(sys_rstn_m), .rst_cause(rst_cause_m), .rst_done(rst_done_m)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: counts edges since pad release, or remaining low cycles after a request.
    logic       m_rstn = 1'b0;
    logic [1:0] m_cause = 2'b00;
    logic       m_done = 1'b0;
    int         m_pad = 0;
    int         m_timer = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_rstn = 1'b0; m_cause = 2'b00; m_done = 1'b0; m_pad = 0; m_timer = 0;
        end else begin
            m_done = 1'b0;
            if (m_rstn) begin
                if (wdt_rst_req) begin
                    m_cause = 2'b10; m_rstn = 1'b0; m_timer = H;
                end else if (sw_rst_req) begin
                    m_cause = 2'b01; m_rstn = 1'b0; m_timer = H;
                end
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) begin m_rstn = 1'b1; m_done = 1'b1; end
            end else begin
                m_pad++;
                if (m_pad == S + H + 1) begin m_rstn = 1'b1; m_done = 1'b1; end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en)
            check("model", {29'd0, sys_rstn, rst_cause, rst_done}, {29'd0, m_rstn, m_cause, m_done});
    end

    // All directed activity happens 1 time unit after the falling edge, between rising edges.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_run(input int budget);
        int n;
        n = 0;
        while (sys_rstn !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (sys_rstn !== 1'b1) check("wait_run_timeout", 32'(sys_rstn), 32'd1);
    endtask

    typedef struct {
        logic       sw;
        logic       wdt;
        logic [1:0] exp_cause;
        int         exp_low;
    } req_vec_t;

    req_vec_t vecs[4];

    initial begin
        int low;
        vecs[0] = '{sw: 1'b1, wdt: 1'b0, exp_cause: 2'b01, exp_low: 16};
        vecs[1] = '{sw: 1'b0, wdt: 1'b1, exp_cause: 2'b10, exp_low: 16};
        vecs[2] = '{sw: 1'b1, wdt: 1'b1, exp_cause: 2'b10, exp_low: 16};
        vecs[3] = '{sw: 1'b1, wdt: 1'b0, exp_cause: 2'b01, exp_low: 16};

        // Power-on with defaults
        resetn = 1'b0;
        resetn_m = 1'b0;
        step();
        mon_en = 1'b1;
        check("reset_rstn", 32'(sys_rstn), 32'd0);
        check("reset_cause", 32'(rst_cause), 32'd0);
        check("reset_done", 32'(rst_done), 32'd0);
        repeat (4) step();
        resetn = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            step();
            check("por_low", 32'(sys_rstn), 32'd0);
        end
        step();
        check("por_rise", 32'(sys_rstn), 32'd1);
        check("por_done", 32'(rst_done), 32'd1);
        check("por_cause", 32'(rst_cause), 32'd0);
        step();
        check("por_done_clr", 32'(rst_done), 32'd0);

        // Request table
        for (int i = 0; i < 4; i++) begin
            wait_run(100);
            repeat (3) step();
            sw_rst_req = vecs[i].sw;
            wdt_rst_req = vecs[i].wdt;
            step();
            sw_rst_req = 1'b0;
            wdt_rst_req = 1'b0;
            check("req_low", 32'(sys_rstn), 32'd0);
            check("req_cause", 32'(rst_cause), 32'(vecs[i].exp_cause));
            low = 0;
            while (sys_rstn !== 1'b1 && low < 100) begin
                step();
                low++;
            end
            check("req_low_cycles", 32'(low), 32'(vecs[i].exp_low));
            check("req_done", 32'(rst_done), 32'd1);
            step();
            check("req_done_clr", 32'(rst_done), 32'd0);
        end

        // Simultaneous requests, then a late software request during HOLD
        repeat (2) step();
        sw_rst_req = 1'b1;
        wdt_rst_req = 1'b1;
        step();
        wdt_rst_req = 1'b0;
        sw_rst_req = 1'b0;
        check("both_cause", 32'(rst_cause), 32'd2);
        repeat (4) step();
        sw_rst_req = 1'b1;
        repeat (3) step();
        sw_rst_req = 1'b0;
        repeat (8) step();
        check("late_still_low", 32'(sys_rstn), 32'd0);
        step();
        check("late_rise_16", 32'(sys_rstn), 32'd1);
        check("late_cause", 32'(rst_cause), 32'd2);

        // Pad reset mid-HOLD after a software request (counter = 7)
        repeat (2) step();
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        check("midhold_cause_sw", 32'(rst_cause), 32'd1);
        repeat (7) step();
        resetn = 1'b0;
        #1;
        check("midhold_rstn", 32'(sys_rstn), 32'd0);
        check("midhold_cause", 32'(rst_cause), 32'd0);
        repeat (2) step();
        resetn = 1'b1;
        for (int e = 1; e <= 18; e++) step();
        check("midhold_low18", 32'(sys_rstn), 32'd0);
        step();
        check("midhold_rise19", 32'(sys_rstn), 32'd1);
        check("midhold_done19", 32'(rst_done), 32'd1);

        // Pad reset in RUN
        repeat (3) step();
        resetn = 1'b0;
        #1;
        check("run_pad_rstn", 32'(sys_rstn), 32'd0);
        check("run_pad_done", 32'(rst_done), 32'd0);
        check("run_pad_cause", 32'(rst_cause), 32'd0);
        step();
        resetn = 1'b1;
        wait_run(100);

        // Minimum parameters
        resetn_m = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            check("min_low", 32'(sys_rstn_m), 32'd0);
        end
        step();
        check("min_rise4", 32'(sys_rstn_m), 32'd1);
        check("min_done4", 32'(rst_done_m), 32'd1);
        step();
        sw_m = 1'b1;
        step();
        sw_m = 1'b0;
        check("min_sw_low", 32'(sys_rstn_m), 32'd0);
        check("min_sw_cause", 32'(rst_cause_m), 32'd1);
        step();
        check("min_sw_rise", 32'(sys_rstn_m), 32'd1);
        check("min_sw_done", 32'(rst_done_m), 32'd1);
        wdt_m = 1'b1;
        step();
        wdt_m = 1'b0;
        check("min_wdt_low", 32'(sys_rstn_m), 32'd0);
        check("min_wdt_cause", 32'(rst_cause_m), 32'd2);
        step();
        check("min_wdt_rise", 32'(sys_rstn_m), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            step();
            sw_rst_req = ($urandom_range(7) == 0);
            wdt_rst_req = ($urandom_range(15) == 0);
            if (!resetn) begin
                if ($urandom_range(3) == 0) resetn = 1'b1;
            end else if ($urandom_range(199) == 0) begin
                resetn = 1'b0;
            end
        end
        sw_rst_req = 1'b0;
        wdt_rst_req = 1'b0;
        resetn = 1'b1;
        repeat (40) step();
        check("final_run", 32'(sys_rstn), 32'd1);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rst_ctrl.md
# rst_ctrl

Chip-level reset controller sitting directly upstream of the core logic and the spare-cell bank, which all consume its `sys_rstn` together with `clk`. It assert-asynchronously / deassert-synchronously conditions the pad reset, stretches every reset to a fixed minimum width, and re-enters reset on software or watchdog requests. It also records the cause of the most recent reset and flags reset release with a one-cycle pulse.

## Interface
- `SYNC_STAGES`, 2: depth of the deassertion synchronizer; legal values 2..4.
- `HOLD_CYCLES`, 16: number of cycles `sys_rstn` is held low after the synchronizer releases or after a request; legal values 1..65535.
- `CNT_W`, 16: hold counter width; must satisfy 2^CNT_W >= HOLD_CYCLES.
- `clk`  in  1  single system clock.
- `resetn`  in  1  pad reset; asynchronous, active-low.
- `sw_rst_req`  in  1  software reset request, synchronous to `clk`; sampled only in RUN.
- `wdt_rst_req`  in  1  watchdog reset request, synchronous to `clk`; sampled only in RUN.
- `sys_rstn`  out  1  conditioned active-low reset to core and spare cells; registered.
- `rst_cause`  out  2  cause of the last reset: 00 pad/power-on, 01 software, 10 watchdog; 11 never driven.
- `rst_done`  out  1  one-cycle pulse in the first cycle `sys_rstn` is high.

## Operation
- **Async clear.** `resetn` low immediately clears all flops, with no clock needed:
  - synchronizer chain = 0, state = ASSERT, counter = 0;
  - `sys_rstn` = 0, `rst_cause` = 00, `rst_done` = 0.
- **Synchronizer.** A shift chain of `SYNC_STAGES` flops shifts in 1 each edge while `resetn` is high. `sync_ok` is the last stage.
- **States:** ASSERT, HOLD, RUN.
  - ASSERT: when `sync_ok` = 1, go to HOLD with counter = 0.
  - HOLD: counter increments each edge. When counter == `HOLD_CYCLES`-1, go to RUN.
  - RUN: if `wdt_rst_req` = 1, go to HOLD with counter = 0 and `rst_cause` = 10. Else if `sw_rst_req` = 1, go to HOLD with counter = 0 and `rst_cause` = 01. Otherwise stay in RUN.
- **Simultaneous requests.** Watchdog has priority.
- **Ignored requests.** Requests in ASSERT or HOLD are ignored; they are not queued and do not restart the counter.
- **Output registers.**
  - `sys_rstn` is the registered value of (next_state == RUN).
  - `rst_done` = 1 on the edge where state moves HOLD -> RUN, cleared on the next edge.
- **`rst_cause` retention.** Changes only on a RUN -> HOLD transition or on async clear. Holds its value through HOLD and RUN.
- **Pad reset mid-sequence.** `resetn` low during HOLD or RUN aborts everything: async clear, cause 00.
- **`resetn` glitch before `sync_ok`.** The chain restarts from 0.
- **Counter.** Unsigned, `CNT_W` bits. It never wraps: it stops at `HOLD_CYCLES`-1 because the state leaves HOLD.
- **`HOLD_CYCLES` = 1.** HOLD lasts exactly one cycle.

## Timing
- **Pad deassertion.** Let edge 1 be the first rising `clk` edge at which `resetn` is sampled high.
  - `sync_ok` = 1 after edge S (S = `SYNC_STAGES`).
  - HOLD is entered after edge S+1.
  - `sys_rstn` rises after edge S+H+1 (H = `HOLD_CYCLES`); `rst_done` is high for that one cycle.
  - With defaults, `sys_rstn` rises after edge 19.
- **Request.** A request sampled at edge n in RUN:
  - `sys_rstn` goes low after edge n;
  - `sys_rstn` rises after edge n+H, i.e. it is low for exactly H cycles;
  - `rst_done` pulses after edge n+H.
- **Assertion latency.** `sys_rstn` follows `resetn` falling with zero clock latency (async clear of the output flop).
- **Glitch-free output.** `sys_rstn` comes straight from a flop, with no combinational logic after it.

## Test plan
- **Power-on, defaults.** Hold `resetn` low 5 cycles, then release. Required: `sys_rstn` = 0 until edge 19; `sys_rstn` = 1 and `rst_done` = 1 after edge 19; `rst_done` = 0 after edge 20; `rst_cause` = 00 throughout.
- **Software reset.** In RUN, pulse `sw_rst_req` for 1 cycle at edge n. Required: `sys_rstn` = 0 from edge n to edge n+16; `rst_cause` = 01; one `rst_done` pulse after edge n+16.
- **Simultaneous requests plus a late request.** Assert `wdt_rst_req` and `sw_rst_req` together. Required: `rst_cause` = 10. Then raise `sw_rst_req` during HOLD. Required: ignored, and `sys_rstn` still rises exactly 16 cycles after the first request.
- **Pad reset mid-HOLD.** Drive `resetn` low mid-HOLD (counter = 7), asynchronously between edges. Required: `sys_rstn` stays 0, `rst_cause` = 00 immediately. After release, the full 19-edge sequence repeats.
- **Pad reset in RUN.** Drive `resetn` low in RUN, between clock edges. Required: `sys_rstn` = 0 before the next edge; `rst_done` = 0.
- **Minimum parameters.** `SYNC_STAGES` = 2, `HOLD_CYCLES` = 1. Required: `sys_rstn` rises after edge 4 from pad release. A request at edge n gives exactly one low cycle, rising after edge n+1.
